// File: rtl/div_nr_param.sv
// Iterative non-restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one add/subtract step per clock, optional two's-complement operands.
module div_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [2*WIDTH-1:0]     numerator,
  input  logic [WIDTH-1:0]       denominator,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       quotient,
  output logic [WIDTH-1:0]       remainder,
  output logic                   div_zero,
  output logic                   overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX, SIGN} state_t;

  state_t               state;
  logic [WIDTH:0]       prem;
  logic [WIDTH-1:0]     dvd_lo;
  logic [WIDTH-1:0]     qbits;
  logic [WIDTH-1:0]     dvsr;
  logic [CW-1:0]        cnt;
  logic                 sgn, neg_q, neg_r, fault_dz, fault_ov;

  logic [2*WIDTH-1:0]   num_mag;
  logic [WIDTH-1:0]     den_mag;
  logic                 add_sub;
  logic [WIDTH:0]       add_a, add_b, sum;
  logic                 q_ovf;

  assign num_mag = (signed_mode && numerator[2*WIDTH-1]) ? -numerator : numerator;
  assign den_mag = (signed_mode && denominator[WIDTH-1]) ? -denominator : denominator;

  // Single WIDTH+1-bit adder shared by the iteration steps and the final
  // remainder fix-up. Wrapping arithmetic is exact because every partial
  // remainder lies in [-dvsr, dvsr).
  always_comb begin
    add_sub = (state == ITER) && !prem[WIDTH];
    add_a   = (state == FIX) ? prem : {prem[WIDTH-1:0], dvd_lo[WIDTH-1]};
    add_b   = add_sub ? ~{1'b0, dvsr} : {1'b0, dvsr};
    sum     = add_a + add_b + {{WIDTH{1'b0}}, add_sub};
  end

  // Quotient bits taken from the sign of each new partial remainder already
  // equal the standard 2*Qraw+1-2^WIDTH conversion including its -1 fix.
  // Magnitude limit: > 2^(W-1)-1 for positive results, > 2^(W-1) for negative.
  assign q_ovf = qbits[WIDTH-1] && (!neg_q || (|qbits[WIDTH-2:0]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      prem      <= '0;
      dvd_lo    <= '0;
      qbits     <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      fault_dz  <= 1'b0;
      fault_ov  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          div_zero <= 1'b0;
          overflow <= 1'b0;
          sgn      <= signed_mode;
          neg_q    <= signed_mode && (numerator[2*WIDTH-1] ^ denominator[WIDTH-1]);
          neg_r    <= signed_mode && numerator[2*WIDTH-1];
          fault_dz <= (denominator == '0);
          fault_ov <= (denominator != '0) && (num_mag[2*WIDTH-1:WIDTH] >= den_mag);
          prem     <= {1'b0, num_mag[2*WIDTH-1:WIDTH]};
          dvd_lo   <= num_mag[WIDTH-1:0];
          dvsr     <= den_mag;
          cnt      <= '0;
          state    <= ITER;
        end
        ITER: if (fault_dz || fault_ov) begin
          quotient  <= '0;
          remainder <= '0;
          div_zero  <= fault_dz;
          overflow  <= fault_ov;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else begin
          prem   <= sum;
          qbits  <= {qbits[WIDTH-2:0], ~sum[WIDTH]};
          dvd_lo <= {dvd_lo[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (prem[WIDTH]) prem <= sum;
          state <= SIGN;
        end
        SIGN: begin
          if (sgn && q_ovf) begin
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= neg_q ? -qbits : qbits;
            remainder <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
